// File: rtl/proc_pkg.sv
// Shared constants and encodings for the simple processor control unit.
package proc_pkg;

    localparam int DW   = 8;
    localparam int NREG = 8;

    typedef enum logic [2:0] {
        OP_MV  = 3'b000,
        OP_MVI = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011
    } opcode_e;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } step_e;

    typedef enum logic [3:0] {
        SEL_R0   = 4'd0,
        SEL_R1   = 4'd1,
        SEL_R2   = 4'd2,
        SEL_R3   = 4'd3,
        SEL_R4   = 4'd4,
        SEL_R5   = 4'd5,
        SEL_R6   = 4'd6,
        SEL_R7   = 4'd7,
        SEL_G    = 4'd8,
        SEL_DIN  = 4'd9,
        SEL_ZERO = 4'd10
    } bus_sel_e;

    function automatic bus_sel_e reg_sel(input logic [2:0] idx);
        return bus_sel_e'({1'b0, idx});
    endfunction

endpackage

// File: rtl/regn.sv
// Load-enabled register with asynchronous active-low clear.
module regn #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] val_q;
    logic [W-1:0] val_d;

    always_comb begin
        val_d = ld ? d : val_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_q <= '0;
        end else begin
            val_q <= val_d;
        end
    end

    assign q = val_q;

endmodule

// File: rtl/simple_proc_ctrl.sv
// Multi-cycle control unit and register datapath for the 8-bit simple processor.
// step | meaning
// T0   | idle; latch DIN into IR when Run is high
// T1   | mv/mvi/nop complete; add/sub load A from Rx
// T2   | add/sub: drive Ry to the external unit, capture G and C
// T3   | add/sub: write G back to Rx
module simple_proc_ctrl
    import proc_pkg::*;
#(
    parameter int P_DW   = DW,
    parameter int P_NREG = NREG
) (
    input  logic            Clock,
    input  logic            Resetn,
    input  logic [P_DW:0]   DIN,
    input  logic            Run,
    output logic            Done,
    output logic [P_DW-1:0] BusWires,
    output logic            C,
    output logic [P_DW-1:0] as_a,
    output logic [P_DW-1:0] as_b,
    output logic            as_ci,
    input  logic [P_DW-1:0] as_s,
    input  logic            as_co
);

    step_e           step_q, step_d;
    logic [P_DW:0]   ir_q, ir_d;
    logic            c_q, c_d;

    logic [P_DW-1:0] r_q [P_NREG];
    logic [P_DW-1:0] a_q;
    logic [P_DW-1:0] g_q;

    logic [P_NREG-1:0] r_ld;
    logic              a_ld;
    logic              g_ld;
    bus_sel_e          sel;
    logic              done;
    logic              ci;
    logic [P_DW-1:0]   bus;

    logic [2:0] op;
    logic [2:0] x_idx;
    logic [2:0] y_idx;

    assign op    = ir_q[P_DW:P_DW-2];
    assign x_idx = ir_q[5:3];
    assign y_idx = ir_q[2:0];

    always_comb begin
        step_d = step_q;
        ir_d   = ir_q;
        c_d    = c_q;
        sel    = SEL_ZERO;
        done   = 1'b0;
        r_ld   = '0;
        a_ld   = 1'b0;
        g_ld   = 1'b0;
        ci     = 1'b0;
        case (step_q)
            T0: begin
                if (Run) begin
                    ir_d   = DIN;
                    step_d = T1;
                end
            end
            T1: begin
                case (op)
                    OP_MV: begin
                        sel          = reg_sel(y_idx);
                        r_ld[x_idx]  = 1'b1;
                        done         = 1'b1;
                        step_d       = T0;
                    end
                    OP_MVI: begin
                        sel          = SEL_DIN;
                        r_ld[x_idx]  = 1'b1;
                        done         = 1'b1;
                        step_d       = T0;
                    end
                    OP_ADD, OP_SUB: begin
                        sel    = reg_sel(x_idx);
                        a_ld   = 1'b1;
                        step_d = T2;
                    end
                    default: begin
                        // reserved opcodes retire as a one-step no-op
                        done   = 1'b1;
                        step_d = T0;
                    end
                endcase
            end
            T2: begin
                sel    = reg_sel(y_idx);
                ci     = ir_q[6];
                g_ld   = 1'b1;
                c_d    = as_co;
                step_d = T3;
            end
            T3: begin
                sel         = SEL_G;
                r_ld[x_idx] = 1'b1;
                done        = 1'b1;
                step_d      = T0;
            end
            default: begin
                step_d = T0;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            step_q <= T0;
            ir_q   <= '0;
            c_q    <= 1'b0;
        end else begin
            step_q <= step_d;
            ir_q   <= ir_d;
            c_q    <= c_d;
        end
    end

    always_comb begin
        case (sel)
            SEL_G:    bus = g_q;
            SEL_DIN:  bus = DIN[P_DW-1:0];
            SEL_ZERO: bus = '0;
            default:  bus = r_q[sel[2:0]];
        endcase
    end

    for (genvar i = 0; i < P_NREG; i++) begin : g_reg
        regn #(.W(P_DW)) u_r (
            .clk   (Clock),
            .rst_n (Resetn),
            .ld    (r_ld[i]),
            .d     (bus),
            .q     (r_q[i])
        );
    end

    regn #(.W(P_DW)) u_a (
        .clk   (Clock),
        .rst_n (Resetn),
        .ld    (a_ld),
        .d     (bus),
        .q     (a_q)
    );

    regn #(.W(P_DW)) u_g (
        .clk   (Clock),
        .rst_n (Resetn),
        .ld    (g_ld),
        .d     (as_s),
        .q     (g_q)
    );

    assign Done     = done;
    assign BusWires = bus;
    assign C        = c_q;
    assign as_a     = a_q;
    assign as_b     = bus;
    assign as_ci    = ci;

endmodule

// File: tb/tb_simple_proc_ctrl.sv
// Randomized self-checking bench for simple_proc_ctrl with an instruction-level model.
module tb_simple_proc_ctrl;

    logic       Clock;
    logic       Resetn;
    logic [8:0] DIN;
    logic       Run;
    logic       Done;
    logic [7:0] BusWires;
    logic       C;
    logic [7:0] as_a;
    logic [7:0] as_b;
    logic       as_ci;
    logic [7:0] as_s;
    logic       as_co;

    simple_proc_ctrl dut (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .DIN      (DIN),
        .Run      (Run),
        .Done     (Done),
        .BusWires (BusWires),
        .C        (C),
        .as_a     (as_a),
        .as_b     (as_b),
        .as_ci    (as_ci),
        .as_s     (as_s),
        .as_co    (as_co)
    );

    // external add/sub unit: A + (ci ? ~B : B) + ci
    assign {as_co, as_s} = {1'b0, as_a} + {1'b0, (as_ci ? ~as_b : as_b)} + {8'd0, as_ci};

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] m_r [8];
    logic [7:0] m_a;
    logic [7:0] m_g;
    logic       m_c;

    typedef struct {
        logic       done;
        logic [7:0] bus;
        logic [7:0] a;
        logic       c;
        logic       ci;
        bit         chk_ci;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic exp_t mk(input logic done, input logic [7:0] bus, input bit chk, input logic ci);
        exp_t e;
        e.done   = done;
        e.bus    = bus;
        e.a      = m_a;
        e.c      = m_c;
        e.ci     = ci;
        e.chk_ci = chk;
        return e;
    endfunction

    initial begin
        forever begin
            exp_t e;
            @(negedge Clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("done",     {31'd0, Done}, {31'd0, e.done});
                check("bus",      {24'd0, BusWires}, {24'd0, e.bus});
                check("as_b",     {24'd0, as_b}, {24'd0, e.bus});
                check("as_a",     {24'd0, as_a}, {24'd0, e.a});
                check("carry",    {31'd0, C}, {31'd0, e.c});
                if (e.chk_ci) check("as_ci", {31'd0, as_ci}, {31'd0, e.ci});
            end
        end
    end

    task automatic step(input bit run, input logic [8:0] din, input exp_t e);
        @(posedge Clock);
        #1;
        Run = run;
        DIN = din;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        step(1'b0, 9'($urandom), mk(1'b0, 8'h00, 1'b0, 1'b0));
    endtask

    task automatic exec(input logic [8:0] ins, input logic [7:0] data, input bit hold,
                        input logic [8:0] hold_din, output logic [7:0] dbus, output int lat);
        logic [2:0] op, x, y;
        bit         arith;
        int         nc;
        logic       run;
        logic [8:0] din;
        logic [8:0] s9;
        exp_t       e;
        op    = ins[8:6];
        x     = ins[5:3];
        y     = ins[2:0];
        arith = (op == 3'd2) || (op == 3'd3);
        nc    = arith ? 4 : 2;
        lat   = 0;
        dbus  = 8'h00;
        for (int k = 0; k < nc; k++) begin
            if (k == 0) begin
                run = 1'b1;
                din = ins;
            end else begin
                run = hold ? 1'b1 : 1'($urandom_range(0, 1));
                din = hold ? hold_din : 9'($urandom);
                if (op == 3'd1 && k == 1) din = {1'($urandom_range(0, 1)), data};
            end
            if (k == 0)                e = mk(1'b0, 8'h00, 1'b0, 1'b0);
            else if (k == 1 && op[2])  e = mk(1'b1, 8'h00, 1'b0, 1'b0);
            else if (k == 1 && op == 3'd0) e = mk(1'b1, m_r[y], 1'b0, 1'b0);
            else if (k == 1 && op == 3'd1) e = mk(1'b1, data, 1'b0, 1'b0);
            else if (k == 1)           e = mk(1'b0, m_r[x], 1'b0, 1'b0);
            else if (k == 2)           e = mk(1'b0, m_r[y], 1'b1, op[0]);
            else                       e = mk(1'b1, m_g, 1'b0, 1'b0);
            step(run, din, e);
            if (k == 1 && !op[2] && op == 3'd0) m_r[x] = m_r[y];
            else if (k == 1 && op == 3'd1)      m_r[x] = data;
            else if (k == 1 && arith)           m_a = m_r[x];
            else if (k == 2) begin
                s9  = {1'b0, m_a} + {1'b0, (op[0] ? ~m_r[y] : m_r[y])} + {8'd0, op[0]};
                m_g = s9[7:0];
                m_c = s9[8];
            end else if (k == 3) m_r[x] = m_g;
            @(negedge Clock);
            if (Done === 1'b1 && lat == 0) begin
                lat  = k + 1;
                dbus = BusWires;
            end
        end
        check("latency", lat, nc);
    endtask

    function automatic logic [8:0] ins_of(input logic [2:0] op, input logic [2:0] x, input logic [2:0] y);
        return {op, x, y};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_r[i] = 8'h00;
        m_a = 8'h00;
        m_g = 8'h00;
        m_c = 1'b0;
    endtask

    initial begin
        logic [7:0] dbus;
        int         lat;
        model_clear();
        Resetn = 1'b0;
        Run    = 1'b0;
        DIN    = 9'd0;
        #12;
        check("rst_done",  {31'd0, Done}, 32'd0);
        check("rst_bus",   {24'd0, BusWires}, 32'd0);
        check("rst_c",     {31'd0, C}, 32'd0);
        check("rst_as_a",  {24'd0, as_a}, 32'd0);
        check("rst_as_ci", {31'd0, as_ci}, 32'd0);
        @(posedge Clock);
        #1;
        Resetn = 1'b1;
        repeat (2) idle();

        exec(ins_of(3'd1, 3'd0, 3'd0), 8'h05, 1'b0, 9'd0, dbus, lat);
        check("mvi_r0", {24'd0, dbus}, 32'h05);
        exec(ins_of(3'd0, 3'd1, 3'd0), 8'h00, 1'b0, 9'd0, dbus, lat);
        check("mv_r1", {24'd0, dbus}, 32'h05);
        exec(ins_of(3'd0, 3'd0, 3'd0), 8'h00, 1'b0, 9'd0, dbus, lat);
        check("r0_kept", {24'd0, dbus}, 32'h05);
        exec(ins_of(3'd2, 3'd0, 3'd1), 8'h00, 1'b0, 9'd0, dbus, lat);
        check("add_5_5", {24'd0, dbus}, 32'h0A);
        check("add_5_5_c", {31'd0, C}, 32'd0);
        exec(ins_of(3'd1, 3'd0, 3'd0), 8'hFF, 1'b0, 9'd0, dbus, lat);
        exec(ins_of(3'd1, 3'd1, 3'd0), 8'h01, 1'b0, 9'd0, dbus, lat);
        exec(ins_of(3'd2, 3'd0, 3'd1), 8'h00, 1'b0, 9'd0, dbus, lat);
        check("add_ff_1", {24'd0, dbus}, 32'h00);
        check("add_ff_1_c", {31'd0, C}, 32'd1);
        exec(ins_of(3'd1, 3'd0, 3'd0), 8'h03, 1'b0, 9'd0, dbus, lat);
        exec(ins_of(3'd1, 3'd1, 3'd0), 8'h05, 1'b0, 9'd0, dbus, lat);
        exec(ins_of(3'd3, 3'd0, 3'd1), 8'h00, 1'b0, 9'd0, dbus, lat);
        check("sub_3_5", {24'd0, dbus}, 32'hFE);
        check("sub_3_5_c", {31'd0, C}, 32'd0);
        exec(ins_of(3'd1, 3'd0, 3'd0), 8'h07, 1'b0, 9'd0, dbus, lat);
        exec(ins_of(3'd3, 3'd0, 3'd1), 8'h00, 1'b0, 9'd0, dbus, lat);
        check("sub_7_5", {24'd0, dbus}, 32'h02);
        check("sub_7_5_c", {31'd0, C}, 32'd1);
        exec(ins_of(3'd2, 3'd0, 3'd0), 8'h00, 1'b0, 9'd0, dbus, lat);
        check("add_self", {24'd0, dbus}, 32'h04);

        exec(ins_of(3'd2, 3'd2, 3'd1), 8'h00, 1'b1, ins_of(3'd5, 3'd2, 3'd1), dbus, lat);
        exec(ins_of(3'd5, 3'd2, 3'd1), 8'h00, 1'b0, 9'd0, dbus, lat);
        check("nop_bus", {24'd0, dbus}, 32'h00);
        check("nop_lat", lat, 32'd2);

        repeat (300) begin
            logic [2:0] op;
            repeat ($urandom_range(0, 2)) idle();
            op = 3'($urandom_range(0, 7));
            exec(ins_of(op, 3'($urandom), 3'($urandom)), 8'($urandom),
                 1'($urandom_range(0, 1)), 9'($urandom), dbus, lat);
        end
        for (int i = 0; i < 8; i++)
            exec(ins_of(3'd0, 3'(i), 3'(i)), 8'h00, 1'b0, 9'd0, dbus, lat);

        exec(ins_of(3'd1, 3'd0, 3'd0), 8'h11, 1'b0, 9'd0, dbus, lat);
        exec(ins_of(3'd1, 3'd1, 3'd0), 8'hF0, 1'b0, 9'd0, dbus, lat);
        step(1'b1, ins_of(3'd2, 3'd0, 3'd1), mk(1'b0, 8'h00, 1'b0, 1'b0));
        step(1'b0, 9'd0, mk(1'b0, m_r[0], 1'b0, 1'b0));
        m_a = m_r[0];
        @(posedge Clock);
        #1;
        Run = 1'b0;
        #2;
        Resetn = 1'b0;
        #1;
        model_clear();
        check("mid_rst_done",  {31'd0, Done}, 32'd0);
        check("mid_rst_bus",   {24'd0, BusWires}, 32'd0);
        check("mid_rst_c",     {31'd0, C}, 32'd0);
        check("mid_rst_as_a",  {24'd0, as_a}, 32'd0);
        check("mid_rst_as_ci", {31'd0, as_ci}, 32'd0);
        @(posedge Clock);
        #1;
        Resetn = 1'b1;
        repeat (3) idle();
        for (int i = 0; i < 8; i++)
            exec(ins_of(3'd0, 3'(i), 3'(i)), 8'h00, 1'b0, 9'd0, dbus, lat);

        repeat (3) @(posedge Clock);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/simple_proc_ctrl.md
Name: simple_proc_ctrl

Overview:
- Multi-cycle control unit and register datapath for the 8-bit simple processor.
- Fetches a 9-bit instruction from DIN on Run and sequences register transfers over an internal 8-bit bus.
- Time-shares the existing external 8-bit add/sub unit for add and sub. It drives that unit's A, B and Ci and captures its S and Co.
- Signals completion of each instruction with Done.

Parameters:
- DW, 8, data/register width; must match the add/sub unit width.
- NREG, 8, number of general registers R0..R7; register index field is 3 bits.

Ports:
- Clock in 1: single rising-edge clock.
- Resetn in 1: asynchronous, active-low reset.
- DIN in 9: instruction word (III XXX YYY), or immediate data in DIN[7:0] during the mvi data step.
- Run in 1: start request; sampled only in state T0.
- Done out 1: high during the final step of each instruction.
- BusWires out 8: current internal bus value.
- C out 1: carry flag from the last add/sub.
- as_a out 8: operand A to the add/sub unit (register A contents).
- as_b out 8: operand B to the add/sub unit (BusWires).
- as_ci out 1: 1 for sub, 0 otherwise (carry-in and invert control).
- as_s in 8: sum/difference from the add/sub unit.
- as_co in 1: carry-out from the add/sub unit.

Behaviour:
- Storage: R0..R7 (DW bits), A, G, IR (9 bits), C, and state register Tstep in {T0, T1, T2, T3}. All are cleared to 0 / T0 asynchronously while Resetn is low.
- Reset output values: Done=0, BusWires=0, C=0, as_a=0, as_ci=0.
- Opcodes (IR[8:6]):
  - 000 mv Rx,Ry
  - 001 mvi Rx,#D
  - 010 add Rx,Ry
  - 011 sub Rx,Ry
  - 1xx: reserved, executed as NOP.
- Field mapping: X = IR[5:3], Y = IR[2:0].
- T0: Done=0, bus=0. If Run=1, IR <= DIN and go to T1; else stay in T0. Run is ignored in T1–T3.
- mv, T1: bus=Ry, Rx <= bus, Done=1, next T0.
- mvi, T1: bus=DIN[7:0], Rx <= bus, Done=1, next T0. DIN must hold the data word in this cycle.
- NOP, T1: bus=0, Done=1, no register writes, next T0.
- add/sub:
  - T1: bus=Rx, A <= bus, next T2.
  - T2: bus=Ry, as_b=Ry, as_ci=IR[6]; G <= as_s, C <= as_co, next T3.
  - T3: bus=G, Rx <= bus, Done=1, next T0.
- Latency from the Run sample:
  - mv / mvi / NOP: Done in the 2nd cycle.
  - add / sub: Done in the 4th cycle.
  - Back-to-back: a new instruction may be accepted in the cycle after Done.
- Arithmetic: modulo 2^DW wrap. C is the raw as_co, so for sub C=1 means no borrow. C is updated only in the add/sub T2 step.
- Self-operands are legal:
  - X==Y: add R0,R0 doubles R0.
  - mv R3,R3 leaves R3 unchanged.
- Done, BusWires and the as_* outputs are combinational decodes of registered state only (Tstep, IR, registers). DIN feeds the bus only in the mvi T1 step, and as_s/as_co affect only G and C. There are no input-to-output paths through the add/sub unit.
- Reset mid-instruction: the step aborts at once and state returns to T0. G, C and the target register are not written. All registers read 0 afterwards.
- At most one register write per cycle; the bus has exactly one source per step.

Decomposition:
- proc_pkg:
  - DW, NREG constants
  - opcode enum (OP_MV, OP_MVI, OP_ADD, OP_SUB)
  - step enum (T0..T3)
  - bus-select enum (SEL_R0..SEL_R7, SEL_G, SEL_DIN, SEL_ZERO)
- Sub-module regn: DW-wide register with load enable and asynchronous active-low clear. It is instantiated for R0..R7, A and G.
- The add/sub unit stays external to this block. It is connected at the top level via the as_* ports.

Test Plan:
- Reset: Resetn=0 mid-T2 of add -> Done=0, BusWires=0, C=0, R0..R7=0; after release, Run=0 keeps state T0.
- mvi R0,#0x05: cycle 0 DIN=9'b001_000_000, Run=1; cycle 1 DIN=0x005 -> Done=1 in cycle 1, R0=0x05 after.
- mv R1,R0 -> Done in 2nd cycle, R1=0x05, R0 unchanged.
- add R0,R1 with R0=R1=0x05 -> as_ci=0 in T2, Done in 4th cycle, R0=0x0A, C=0. Then R0=0xFF, R1=0x01 -> R0=0x00, C=1.
- sub R0,R1 with R0=0x03, R1=0x05 -> as_ci=1 in T2, R0=0xFE, C=0. With R0=0x07 -> R0=0x02, C=1.
- Run held high through add, then opcode 1xx -> IR not reloaded before Done. NOP completes in 2 cycles with no register or C change.
